// File: rtl/axis2bram_banked.sv
// axis2bram_banked: AXI4-Stream to banked BRAM writer.
// Each stream beat holds NUM_BANKS BRAM words. Parallel mode writes all of
// them in one cycle, one word per bank. Serial mode writes them into bank 0,
// one word per cycle. The block also provides tlast-based early termination,
// a sticky length-mismatch flag and a one-cycle done pulse.
module axis2bram_banked #(
  parameter int AXI_DATA_WIDTH  = 512,
  parameter int BRAM_DATA_WIDTH = 128,
  parameter int NUM_BANKS       = 4,
  parameter int BRAM_ADDR_WIDTH = 16,
  parameter int XFER_SIZE_WIDTH = 32,
  parameter int BRAM_DELAY      = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_start,
  input  logic                                 i_mode,
  input  logic [BRAM_ADDR_WIDTH-1:0]           i_base_addr,
  input  logic [XFER_SIZE_WIDTH-1:0]           i_size_bytes,
  input  logic                                 i_ready,
  output logic                                 o_idle,
  output logic                                 o_done,
  output logic                                 o_err_len,
  output logic [XFER_SIZE_WIDTH-1:0]           o_beats,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic [AXI_DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic                                 s_axis_tlast,
  output logic [NUM_BANKS-1:0]                 o_wren,
  output logic [BRAM_ADDR_WIDTH-1:0]           o_wraddr,
  output logic [NUM_BANKS*BRAM_DATA_WIDTH-1:0] o_wrdata
);

  localparam int BYTES_PER_BEAT = AXI_DATA_WIDTH / 8;
  localparam int BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);
  localparam int LANE_SHIFT     = $clog2(NUM_BANKS);
  localparam int LANE_W         = (NUM_BANKS > 1) ? LANE_SHIFT : 1;
  localparam int FLUSH_W        = (BRAM_DELAY > 0) ? $clog2(BRAM_DELAY + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DRAIN,
    S_FLUSH
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                                 r_mode;
  logic [BRAM_ADDR_WIDTH-1:0]           r_base;
  logic [XFER_SIZE_WIDTH-1:0]           r_tgt;
  logic [XFER_SIZE_WIDTH-1:0]           r_beats;
  logic                                 r_err;
  logic                                 r_ended;
  logic                                 r_done;
  logic [AXI_DATA_WIDTH-1:0]            r_hold;
  logic [LANE_W-1:0]                    r_lane;
  logic [FLUSH_W-1:0]                   r_flush_cnt;
  logic [NUM_BANKS-1:0]                 r_wren;
  logic [BRAM_ADDR_WIDTH-1:0]           r_wraddr;
  logic [NUM_BANKS*BRAM_DATA_WIDTH-1:0] r_wrdata;

  logic [XFER_SIZE_WIDTH:0]             w_size_rnd;
  logic [XFER_SIZE_WIDTH-1:0]           w_tgt;
  logic [XFER_SIZE_WIDTH-1:0]           w_beats_inc;
  logic [XFER_SIZE_WIDTH-1:0]           w_beat_idx;
  logic [BRAM_ADDR_WIDTH-1:0]           w_drain_addr;
  logic [BRAM_DATA_WIDTH-1:0]           w_lane_data;
  logic                                 w_hold_full;
  logic                                 w_accept;
  logic                                 w_reach;
  logic                                 w_end;
  logic                                 w_len_err;
  logic                                 w_last_lane;
  logic                                 w_flush_done;

  // Round the byte count up to whole beats; the extra top bit keeps the
  // rounding addition from overflowing for sizes near the top of the range.
  assign w_size_rnd   = {1'b0, i_size_bytes} + (XFER_SIZE_WIDTH + 1)'(BYTES_PER_BEAT - 1);
  assign w_tgt        = XFER_SIZE_WIDTH'(w_size_rnd >> BEAT_SHIFT);

  assign w_accept     = s_axis_tvalid && s_axis_tready;
  assign w_beats_inc  = r_beats + {{(XFER_SIZE_WIDTH-1){1'b0}}, 1'b1};
  assign w_reach      = (w_beats_inc == r_tgt);
  assign w_end        = w_accept && (s_axis_tlast || w_reach);
  // A mismatch is either tlast before the target or no tlast on the target beat.
  assign w_len_err    = w_accept && (s_axis_tlast != w_reach);

  // The beat being drained was already counted, so its index is one below r_beats.
  assign w_beat_idx   = r_beats - {{(XFER_SIZE_WIDTH-1){1'b0}}, 1'b1};
  assign w_drain_addr = r_base + BRAM_ADDR_WIDTH'(w_beat_idx << LANE_SHIFT)
                        + BRAM_ADDR_WIDTH'(r_lane);
  assign w_lane_data  = r_hold[r_lane*BRAM_DATA_WIDTH +: BRAM_DATA_WIDTH];
  assign w_last_lane  = (r_lane == LANE_W'(NUM_BANKS - 1));
  assign w_flush_done = (r_flush_cnt == FLUSH_W'(BRAM_DELAY));

  // State register: reset to IDLE at any time, which drops any partial transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: decide whether to start, accept, drain lanes or wait out the BRAM delay.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = (w_tgt == '0) ? S_FLUSH : S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_accept) begin
          if (r_mode) begin
            w_next = S_DRAIN;
          end else if (w_end) begin
            w_next = S_FLUSH;
          end
        end
      end
      S_DRAIN: begin
        if (w_last_lane) begin
          w_next = r_ended ? S_FLUSH : S_BUSY;
        end
      end
      S_FLUSH: begin
        if (w_flush_done) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs: idle flag and stream ready, which stays low while the hold register drains.
  always_comb begin
    o_idle        = (r_state == S_IDLE);
    w_hold_full   = (r_state == S_DRAIN);
    s_axis_tready = (r_state == S_BUSY) && i_ready && !w_hold_full;
  end

  // Datapath: latch the transfer setup, count beats, register BRAM writes and time the flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= 1'b0;
      r_base      <= '0;
      r_tgt       <= '0;
      r_beats     <= '0;
      r_err       <= 1'b0;
      r_ended     <= 1'b0;
      r_done      <= 1'b0;
      r_hold      <= '0;
      r_lane      <= '0;
      r_flush_cnt <= '0;
      r_wren      <= '0;
      r_wraddr    <= '0;
      r_wrdata    <= '0;
    end else begin
      r_wren <= '0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mode      <= i_mode;
            r_base      <= i_base_addr;
            r_tgt       <= w_tgt;
            r_beats     <= '0;
            r_err       <= 1'b0;
            r_ended     <= 1'b0;
            r_lane      <= '0;
            r_flush_cnt <= '0;
          end
        end
        S_BUSY: begin
          r_flush_cnt <= '0;
          if (w_accept) begin
            r_beats <= w_beats_inc;
            if (w_end) begin
              r_ended <= 1'b1;
            end
            if (w_len_err) begin
              r_err <= 1'b1;
            end
            if (r_mode) begin
              r_hold <= s_axis_tdata;
              r_lane <= '0;
            end else begin
              r_wren   <= '1;
              r_wraddr <= r_base + BRAM_ADDR_WIDTH'(r_beats);
              r_wrdata <= s_axis_tdata;
            end
          end
        end
        S_DRAIN: begin
          r_flush_cnt <= '0;
          r_wren      <= NUM_BANKS'(1);
          r_wraddr    <= w_drain_addr;
          r_wrdata    <= (NUM_BANKS*BRAM_DATA_WIDTH)'(w_lane_data);
          r_lane      <= r_lane + LANE_W'(1);
        end
        S_FLUSH: begin
          if (w_flush_done) begin
            r_done <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt + FLUSH_W'(1);
          end
        end
        default: begin
          r_flush_cnt <= '0;
        end
      endcase
    end
  end

  assign o_done    = r_done;
  assign o_err_len = r_err;
  assign o_beats   = r_beats;
  assign o_wren    = r_wren;
  assign o_wraddr  = r_wraddr;
  assign o_wrdata  = r_wrdata;

endmodule

// File: doc/axis2bram_banked.md
# axis2bram_banked

Parametrised AXI4-Stream-to-BRAM writer for the memory-buffer subsystem. One wide stream beat is split into `NUM_BANKS` BRAM-word lanes. In parallel mode all lanes are written to `NUM_BANKS` banks in one cycle; in serial mode the lanes are written one per cycle into bank 0. The block adds a base address, `tlast`-based early termination, a length-mismatch flag and a one-cycle done pulse.

## Interface
- `AXI_DATA_WIDTH`, 512, stream data width; must equal `NUM_BANKS*BRAM_DATA_WIDTH`
- `BRAM_DATA_WIDTH`, 128, BRAM word width
- `NUM_BANKS`, 4, lanes per beat; power of two, 1..16
- `BRAM_ADDR_WIDTH`, 16, BRAM address width
- `XFER_SIZE_WIDTH`, 32, byte-count width
- `BRAM_DELAY`, 2, cycles to wait after the last write before completion
- `clk` in 1 — clock
- `rst_n` in 1 — reset, asynchronous, active-low
- `i_start` in 1 — start pulse; sampled only in IDLE
- `i_mode` in 1 — 0 = parallel, 1 = serial; latched at start
- `i_base_addr` in `BRAM_ADDR_WIDTH` — first write address; latched at start
- `i_size_bytes` in `XFER_SIZE_WIDTH` — transfer length; latched at start
- `i_ready` in 1 — downstream allow; 0 stalls acceptance
- `o_idle` out 1 — high in IDLE
- `o_done` out 1 — one-cycle pulse on the FLUSH→IDLE transition
- `o_err_len` out 1 — sticky mismatch flag; cleared on the next accepted start
- `o_beats` out `XFER_SIZE_WIDTH` — beats accepted in the current or last transfer
- `s_axis_tvalid` in 1; `s_axis_tready` out 1; `s_axis_tdata` in `AXI_DATA_WIDTH`; `s_axis_tlast` in 1
- `o_wren` out `NUM_BANKS` — per-bank write enable
- `o_wraddr` out `BRAM_ADDR_WIDTH` — shared write address
- `o_wrdata` out `NUM_BANKS*BRAM_DATA_WIDTH` — lane k at bits [k*BRAM_DATA_WIDTH +: BRAM_DATA_WIDTH]

## Operation
- Target beat count: `beats_tgt = ceil(i_size_bytes / (AXI_DATA_WIDTH/8))`, computed with a shift (no divider). Width is `XFER_SIZE_WIDTH`.
- States are IDLE, BUSY, DRAIN and FLUSH.
- **IDLE**
  - On `i_start`: latch mode, base, `beats_tgt`; clear `o_beats` and `o_err_len`.
  - Next state is BUSY, or FLUSH directly if `beats_tgt == 0`.
- **BUSY**
  - `s_axis_tready = i_ready && !hold_full`. A beat is accepted when `tvalid && tready`.
  - Parallel mode: each accepted beat is written to all banks at `base + beat_idx`.
  - Serial mode: the accepted beat is loaded into a hold register and the state moves to DRAIN.
- **DRAIN** (serial only)
  - Lane j is written to bank 0 (`o_wren = 1`) at `base + beat_idx*NUM_BANKS + j`, for j = 0..NUM_BANKS-1, one lane per cycle.
  - `tready` is 0 throughout.
  - After lane NUM_BANKS-1, return to BUSY, or go to FLUSH if the transfer has ended.
- **Transfer end:** the accepted beat has `tlast = 1`, or the accepted beat count reaches `beats_tgt`.
  - `o_err_len` sets if `tlast` arrives before `beats_tgt`, or if beat `beats_tgt` has `tlast = 0`. The transfer ends either way.
  - No further beats are accepted after the end.
- **FLUSH**
  - Count `BRAM_DELAY` cycles after the last write, then pulse `o_done` and return to IDLE.
- **Address arithmetic:** addresses wrap modulo 2^`BRAM_ADDR_WIDTH`. No error is raised on wrap.
- `i_start` outside IDLE is ignored.
- `i_ready` deasserted mid-transfer stalls acceptance only. An in-flight DRAIN completes regardless.

## Timing
- Write outputs are registered. `o_wren`/`o_wraddr`/`o_wrdata` for a beat accepted at edge N are valid in cycle N+1.
- Parallel throughput: 1 beat/cycle.
- Serial throughput: 1 beat per NUM_BANKS+1 cycles.
- Start to first possible `tready`: 1 cycle (the IDLE→BUSY edge).
- `o_done` pulse occurs BRAM_DELAY+1 cycles after the cycle carrying the last `o_wren`.
- With `beats_tgt == 0`: `o_done` pulses BRAM_DELAY+1 cycles after start; no writes occur.
- **Reset (asynchronous, any state):**
  - State IDLE.
  - `o_idle = 1`.
  - `o_done`, `o_err_len`, `o_wren`, `s_axis_tready` = 0.
  - `o_beats`, `o_wraddr`, `o_wrdata`, the hold register and all counters = 0.
- Reset mid-transfer discards the partial transfer and produces no `o_done` pulse.
- `o_idle` rises in the same cycle `o_done` pulses.

## Test plan
- **Parallel, nominal:** NUM_BANKS=4, base=0x10, size=256 B (4 beats), `tlast` on beat 4, continuous valid.
  - `o_wren=4'hF` at addr 0x10..0x13 on consecutive cycles; `o_beats=4`; `o_err_len=0`; `o_done` 3 cycles after the last write.
- **Serial:** base=0, size=128 B (2 beats).
  - 8 single writes, `o_wren=4'b0001` at addr 0..7, carrying lanes 0..3 of beat 0 then lanes 0..3 of beat 1.
  - `tready` low for 4 cycles after each beat.
- **Early tlast:** size=512 B (8 beats), `tlast` on beat 3.
  - 3 writes; `o_err_len=1`; `o_beats=3`; `tready` stays 0 after beat 3; `o_done` pulses.
  - Next start clears `o_err_len`.
- **Backpressure and wrap:** `i_ready` toggles every other cycle, `tvalid` random, BRAM_ADDR_WIDTH=4, base=0xE, 4 beats.
  - Addresses 0xE, 0xF, 0x0, 0x1, with no duplicated or dropped beats.
- **Zero size and start-while-busy:** size=0 → no `o_wren`, `o_done` after 3 cycles.
  - A second `i_start` asserted during BUSY is ignored (`o_beats` is not cleared).
- **Reset mid-DRAIN:** assert `rst_n=0` after lane 1 of a serial beat.
  - All outputs go to their reset values immediately; no `o_done` pulse.
  - A new transfer after reset completes normally.
